// File: rtl/toggle_handshake_tx.sv
// toggle_handshake_tx: launch side of a toggle-handshake word crossing.
// Optional macro TOGGLE_HANDSHAKE_TX_TEST_BYPASS_EN adds test_mode ack bypass.
module toggle_handshake_tx #(
  parameter int DATA_W     = 32,
  parameter int SYNC_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
`ifdef TOGGLE_HANDSHAKE_TX_TEST_BYPASS_EN
  input  logic              test_mode,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] xing_data,
  output logic              xing_req,
  input  logic              xing_ack,
  output logic              done,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  w_ack_s;

  logic              r_ready;
  logic              r_req;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_data;

  logic              w_ready_nxt;
  logic              w_req_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  logic              w_hs;

  // Resynchronise the far-side acknowledge toggle into this domain
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], xing_ack};
    end
  end

`ifdef TOGGLE_HANDSHAKE_TX_TEST_BYPASS_EN
  assign w_ack_s = test_mode ? xing_ack
                             : r_sync[SYNC_DEPTH-1];
`else
  assign w_ack_s = r_sync[SYNC_DEPTH-1];
`endif

  assign w_hs = in_valid & r_ready;

  // Next-state and registered-output logic for the transfer FSM
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_ack_s != r_req) begin
          w_err_nxt = 1'b1;
        end
        if (w_hs) begin
          w_data_nxt  = in_data;
          w_ready_nxt = 1'b0;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (w_ack_s != r_req) begin
          w_err_nxt = 1'b1;
        end
        w_req_nxt   = ~r_req;
        w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_ack_s == r_req) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any word in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign in_ready     = r_ready;
  assign xing_req     = r_req;
  assign xing_data    = r_data;
  assign done         = r_done;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
// tb_toggle_handshake_tx: scoreboard bench for toggle_handshake_tx.
// Words accepted are queued; each done pulse pops and checks xing_data.
module tb_toggle_handshake_tx;

  localparam int DW = 32;
  localparam int SD = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] xing_data;
  logic          xing_req;
  logic          xing_ack;
  logic          done;
  logic          protocol_err;
`ifdef TOGGLE_HANDSHAKE_TX_TEST_BYPASS_EN
  logic          test_mode = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sb_q[$];

  toggle_handshake_tx #(
    .DATA_W    (DW),
    .SYNC_DEPTH(SD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef TOGGLE_HANDSHAKE_TX_TEST_BYPASS_EN
    .test_mode   (test_mode),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .xing_data   (xing_data),
    .xing_req    (xing_req),
    .xing_ack    (xing_ack),
    .done        (done),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  // push accepted words; a reset discards anything pending
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      sb_q.delete();
    end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
      sb_q.push_back(in_data);
    end
  end

  // pop on each completion and check the word that was crossed
  always @(negedge clock) begin
    logic [DW-1:0] exp_w;
    if (done === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_pop: done with empty queue, xing_data=%h",
                 xing_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (xing_data !== exp_w) begin
          n_fail++;
          $display("FAIL sb_data: got %h expected %h", xing_data, exp_w);
        end
      end
    end
  end

  task automatic test_reset();
    logic [35:0] obs;
    logic [35:0] exp;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom);
      in_data  = $urandom;
      xing_ack = 1'($urandom);
      @(posedge clock);
      @(negedge clock);
      obs = {in_ready, done, xing_req, protocol_err, xing_data};
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    xing_ack = 1'b0;
  endtask

  task automatic test_transfer();
    logic [35:0] obs;
    logic [35:0] exp;
    logic        e_rdy;
    logic        e_done;
    logic        e_req;
    logic [31:0] e_data;
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      @(posedge clock);
      @(negedge clock);
      e_rdy  = (e == 8) || (e >= 17);
      e_done = (e == 8) || (e == 17);
      e_req  = (e >= 1) && (e <= 9);
      e_data = (e >= 9) ? 32'h12345678 : 32'hDEADBEEF;
      obs = {in_ready, done, xing_req, protocol_err, xing_data};
      exp = {e_rdy, e_done, e_req, 1'b0, e_data};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL xfer_edge%0d: got %h expected %h", e, obs, exp);
      end
      if (e == 1)  in_data  = 32'h2;
      if (e == 4)  xing_ack = 1'b1;
      if (e == 7)  in_data  = 32'h12345678;
      if (e == 13) xing_ack = 1'b0;
      if (e == 17) in_valid = 1'b0;
    end
  endtask

  task automatic test_stray_ack();
    logic [35:0] obs;
    logic [35:0] exp;
    xing_ack = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clock);
      @(negedge clock);
      obs = {in_ready, done, xing_req, protocol_err, xing_data};
      exp = {1'b1, 1'b0, 1'b0, (e >= 4), 32'h12345678};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stray_edge%0d: got %h expected %h", e, obs, exp);
      end
      if (e == 5) xing_ack = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] obs;
    logic [35:0] exp;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    n_tests++;
    if (protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b expected 0", protocol_err);
    end
    in_data  = 32'hA5A5_5A5A;
    in_valid = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
    end
    n_tests++;
    if ({in_ready, xing_req, xing_data} !== {1'b0, 1'b1, 32'hA5A5_5A5A}) begin
      n_fail++;
      $display("FAIL mid_wait: rdy=%b req=%b data=%h expected 0 1 a5a55a5a",
               in_ready, xing_req, xing_data);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      obs = {in_ready, done, xing_req, protocol_err, xing_data};
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_reset%0d: got %h expected %h", e, obs, exp);
      end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_drain();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d words pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    xing_ack = 1'b0;
    test_reset();
    test_transfer();
    test_stray_ack();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
